// File: rtl/sched_pkg.sv
// sched_pkg: scheduler state encoding and channel-index width helper
package sched_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_START, S_WAIT, S_NEXT} state_t;
    localparam int TONGDAO_W = 32;
    function automatic int chan_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/fifo_poll_sched_chan_mux.sv
// chan_mux: selects the granted and scanned channel slices and decodes rdreq onto the granted FIFO
module chan_mux
    import sched_pkg::*;
#(
    parameter int CH_NUM  = 30,
    parameter int USEDW_W = 12,
    parameter int DATA_W  = 64,
    parameter int IW      = chan_w(CH_NUM)
) (
    input  logic [IW-1:0]             sel,
    input  logic [IW-1:0]             scan,
    input  logic [CH_NUM*USEDW_W-1:0] usedw_bus,
    input  logic [CH_NUM*DATA_W-1:0]  q_bus,
    input  logic                      rd,
    output logic [USEDW_W-1:0]        rdusedw,
    output logic [USEDW_W-1:0]        scan_usedw,
    output logic [DATA_W-1:0]         fifo_out,
    output logic [CH_NUM-1:0]         rdreq_bus
);
    always_comb begin
        rdusedw    = '0;
        scan_usedw = '0;
        fifo_out   = '0;
        rdreq_bus  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (sel == IW'(i + 1)) begin
                rdusedw      = usedw_bus[i*USEDW_W +: USEDW_W];
                fifo_out     = q_bus[i*DATA_W +: DATA_W];
                rdreq_bus[i] = rd;
            end
            if (scan == IW'(i + 1))
                scan_usedw = usedw_bus[i*USEDW_W +: USEDW_W];
        end
    end
endmodule

// File: rtl/fifo_poll_sched.sv
// fifo_poll_sched: round-robin FIFO poll scheduler for a shared packetiser; SCHED_TIMEOUT_EN adds a wait watchdog
module fifo_poll_sched
    import sched_pkg::*;
#(
    parameter int CH_NUM  = 30,
    parameter int YUZHI   = 128,
    parameter int USEDW_W = 12,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CH_NUM*USEDW_W-1:0] usedw_bus,
    input  logic [CH_NUM*DATA_W-1:0]  q_bus,
    output logic [CH_NUM-1:0]         rdreq_bus,
    output logic                      start,
    output logic [TONGDAO_W-1:0]      tongdao,
    output logic [USEDW_W-1:0]        rdusedw,
    output logic [DATA_W-1:0]         fifo_out,
    input  logic                      rdreq,
    input  logic                      over,
    output logic                      busy,
    output logic                      timeout_err
);
    localparam int IW = chan_w(CH_NUM);
    state_t state;
    logic [IW-1:0] ptr, sel;
    logic [USEDW_W-1:0] scan_usedw;
    logic to_hit;
    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] n);
        return (n == IW'(CH_NUM)) ? IW'(1) : n + 1'b1;
    endfunction
    assign tongdao = TONGDAO_W'(sel);
    chan_mux #(.CH_NUM(CH_NUM), .USEDW_W(USEDW_W), .DATA_W(DATA_W), .IW(IW)) u_mux (
        .sel(sel),
        .scan(ptr),
        .usedw_bus(usedw_bus),
        .q_bus(q_bus),
        .rd(rdreq & busy),
        .rdusedw(rdusedw),
        .scan_usedw(scan_usedw),
        .fifo_out(fifo_out),
        .rdreq_bus(rdreq_bus)
    );
`ifdef SCHED_TIMEOUT_EN
    logic [15:0] wait_cnt;
    assign to_hit = wait_cnt == 16'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt    <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            timeout_err <= timeout_err | (state == S_WAIT && !over && to_hit);
        end
    end
`else
    assign to_hit      = 1'b0 & (TIMEOUT > 0);
    assign timeout_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ptr   <= IW'(1);
            sel   <= IW'(1);
            start <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= en ? S_SCAN : S_IDLE;
                S_SCAN: begin
                    if (scan_usedw >= USEDW_W'(YUZHI)) begin
                        sel   <= ptr;
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= S_START;
                    end else begin
                        ptr   <= nxt(ptr);
                        state <= en ? S_SCAN : S_IDLE;
                    end
                end
                S_START: begin
                    start <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (over || to_hit) begin
                        busy  <= 1'b0;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    ptr   <= nxt(sel);
                    state <= en ? S_SCAN : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_poll_sched.sv
// tb_fifo_poll_sched: randomized self-checking bench against a grant-order/latency model of the scheduler
module tb_fifo_poll_sched;
    localparam int CH = 30, YZ = 128, UW = 12, DW = 64, TO = 1024;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, rdreq = 1'b0, over = 1'b0;
    logic [CH*UW-1:0] usedw_bus;
    logic [CH*DW-1:0] q_bus;
    logic [CH-1:0] rdreq_bus;
    logic start, busy, timeout_err;
    logic [31:0] tongdao;
    logic [UW-1:0] rdusedw;
    logic [DW-1:0] fifo_out;
    logic [UW-1:0] uw [CH];
    logic [DW-1:0] qv [CH];
    int checks = 0, errors = 0;
    int c, mp;

    fifo_poll_sched dut (
        .clk(clk), .rst(rst), .en(en), .usedw_bus(usedw_bus), .q_bus(q_bus),
        .rdreq_bus(rdreq_bus), .start(start), .tongdao(tongdao), .rdusedw(rdusedw),
        .fifo_out(fifo_out), .rdreq(rdreq), .over(over), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        usedw_bus = '0;
        q_bus     = '0;
        for (int i = 0; i < CH; i++) begin
            usedw_bus[i*UW +: UW] = uw[i];
            q_bus[i*DW +: DW]     = qv[i];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nxt(input int n);
        return n == CH ? 1 : n + 1;
    endfunction

    // First eligible channel at or after p in round-robin order, and its distance from p
    task automatic find(input int p, output int ch, output int d);
        ch = 0;
        d  = 0;
        for (int i = 0; i < CH; i++)
            if (ch == 0 && uw[(p - 1 + i) % CH] >= UW'(YZ)) begin
                ch = (p - 1 + i) % CH + 1;
                d  = i;
            end
    endtask

    // extra = 1 when the FSM is scanning p now, 2 when it is in S_NEXT/S_IDLE headed for p
    task automatic expect_grant(input int extra, input int p, input logic rnd_over);
        int ch, d, n;
        find(p, ch, d);
        n = 0;
        while (!start && n < d + extra + 8) begin
            over = rnd_over ? 1'($urandom) : 1'b0;
            tick;
            n++;
        end
        over = 1'b0;
        chk("grant_gap", n, d + extra);
        chk("tongdao", tongdao, ch);
        chk("rdusedw", rdusedw, uw[ch-1]);
        chk("fifo_out", fifo_out, qv[ch-1]);
        chk("busy_start", busy, 1);
        c = ch;
    endtask

    task automatic finish_packet(input int len);
        for (int i = 0; i < len; i++) begin
            rdreq = 1'($urandom);
            tick;
            chk("rdreq_route", rdreq_bus, rdreq ? 64'(1) << (c - 1) : 64'(0));
            chk("tongdao_hold", tongdao, c);
            chk("start_once", start, 0);
            chk("busy_wait", busy, 1);
        end
        over  = 1'b1;
        rdreq = 1'b1;
        tick;
        over = 1'b0;
        chk("busy_next", busy, 0);
        chk("rdreq_next", rdreq_bus, 0);
        rdreq = 1'b0;
    endtask

    task automatic rand_uw;
        int ch, d;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 15))
                0: uw[i] = UW'($urandom_range(YZ, 4095));
                1: uw[i] = UW'(YZ);
                2: uw[i] = UW'(YZ - 1);
                default: uw[i] = UW'($urandom_range(0, YZ - 1));
            endcase
        end
        find(1, ch, d);
        if (ch == 0) uw[$urandom_range(0, CH - 1)] = UW'(YZ);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            uw[i] = '0;
            qv[i] = {$urandom, $urandom};
        end
        tick;
        tick;
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tongdao", tongdao, 1);
        chk("rst_rdreq_bus", rdreq_bus, 0);
        chk("rst_timeout", timeout_err, 0);
        // All channels empty: continuous scanning, no grant
        rst = 1'b0;
        en  = 1'b1;
        tick;
        mp = 1;
        repeat (199) begin
            rdreq = 1'($urandom);
            over  = 1'($urandom);
            tick;
            mp = nxt(mp);
            chk("empty_start", start, 0);
            chk("empty_rdreq", rdreq_bus, 0);
            chk("empty_busy", busy, 0);
        end
        rdreq = 1'b0;
        over  = 1'b0;
        // Single channel 7 at exactly the threshold; second grant only after a full lap
        uw[6] = UW'(YZ);
        expect_grant(1, mp, 1'b0);
        finish_packet(4);
        expect_grant(2, nxt(c), 1'b1);
        // Park the pointer at 30, then check 30 -> 1 wrap order
        uw[6]  = '0;
        uw[28] = 12'd150;
        finish_packet(2);
        expect_grant(2, nxt(c), 1'b1);
        uw[28] = '0;
        uw[29] = 12'd200;
        uw[0]  = 12'd200;
        finish_packet(3);
        expect_grant(2, nxt(c), 1'b1);
        chk("wrap_first", tongdao, 30);
        finish_packet(1);
        expect_grant(2, nxt(c), 1'b1);
        chk("wrap_second", tongdao, 1);
        // One below threshold is never granted; raising it grants on the next pass
        for (int i = 0; i < CH; i++) uw[i] = '0;
        uw[2] = UW'(YZ - 1);
        finish_packet(2);
        tick;
        mp = nxt(c);
        repeat (39) begin
            chk("below_thr_start", start, 0);
            tick;
            mp = nxt(mp);
        end
        uw[2] = UW'(YZ);
        expect_grant(1, mp, 1'b0);
        // en dropped mid-grant: packet completes, FSM parks in idle
        en = 1'b0;
        finish_packet(2);
        tick;
        chk("en_off_busy", busy, 0);
        repeat (10) tick;
        chk("en_off_start", start, 0);
        en = 1'b1;
        expect_grant(2, nxt(c), 1'b0);
        repeat (15) begin
            rand_uw;
            finish_packet($urandom_range(1, 6));
            expect_grant(2, nxt(c), 1'b1);
        end
        // Reset in the middle of a packet
        rdreq = 1'b1;
        tick;
        chk("pre_rst_route", rdreq_bus, 64'(1) << (c - 1));
        rst = 1'b1;
        tick;
        chk("mid_rst_rdreq_bus", rdreq_bus, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tongdao", tongdao, 1);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        rst   = 1'b0;
        rdreq = 1'b0;
        expect_grant(2, 1, 1'b0);
        // Packetiser never finishes
        over = 1'b0;
        repeat (TO) tick;
        chk("wd_busy_hold", busy, 1);
        chk("wd_no_err_yet", timeout_err, 0);
        tick;
`ifdef SCHED_TIMEOUT_EN
        chk("wd_abort_busy", busy, 0);
        chk("wd_err", timeout_err, 1);
        expect_grant(2, nxt(c), 1'b0);
        chk("wd_err_sticky", timeout_err, 1);
`else
        chk("wait_forever_busy", busy, 1);
        chk("wait_forever_err", timeout_err, 0);
        repeat (100) tick;
        chk("wait_forever_busy2", busy, 1);
        chk("wait_forever_start", start, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
